modexp_ctrl: RTL and testbench
==============================

Name: modexp_ctrl

Overview:
- Constant-time left-to-right square-and-multiply controller for 255-bit field elements.
- Drives an external modmul pipeline, acting as the initiator/client that feeds operands and collects products.
- Computes result = base^exp in the field, e.g. inversion via Fermat (exp = p-2) or square-root exponentiations.
- Represents 1 with the `one` input, so it works unchanged for plain or Montgomery-domain modmul instances.

Parameters:
- EXP_W, 255: exponent width in bits, equal to the number of scanned exponent bits.
- MM_LAT, 3: modmul latency. Operands stable from edge k produce a valid product on mm_d after edge k+MM_LAT. Must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- base  input  255  base operand, latched on start.
- exp  input  EXP_W  exponent, latched on start.
- one  input  255  field representation of 1, latched on start.
- busy  output  1  high from the start-accept edge until the done edge.
- done  output  1  one-cycle pulse; result valid.
- result  output  255  final value, held until the next start is accepted.
- mm_a  output  255  modmul operand A, registered.
- mm_b  output  255  modmul operand B, registered.
- mm_d  input  255  modmul product.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE; busy=0, done=0, result=0, mm_a=0, mm_b=0; internal acc, base, exp and counters cleared.
- Reset mid-operation aborts the computation immediately, with no done pulse. The next start after reset computes fresh.
- States:
  - IDLE: on start=1 at edge t0, latch base/exp/one, set acc=one, bit index i=EXP_W-1, wait counter w=0, mm_a=mm_b=one, busy=1, go to SQR.
  - SQR: w increments each edge. At the edge where w reaches MM_LAT-1, acc<=mm_d, mm_a<=mm_d, mm_b<=base_l, w<=0, go to MUL.
  - MUL: always issued, which keeps the computation constant-time. At the edge where w reaches MM_LAT-1:
    - Update acc: acc<= exp_l[i] ? mm_d : acc.
    - If i>0: i<=i-1, mm_a=mm_b=new acc, go to SQR.
    - If i=0: result<=new acc, done<=1, busy<=0, go to IDLE.
- Timing: each operation occupies exactly MM_LAT cycles and there are 2*EXP_W operations. The done edge is t0 + 2*EXP_W*MM_LAT. The controller never reads mm_d at any other edge.
- Constant time: cycle count and the mm_a/mm_b operand pattern are independent of exp bit values. Only the acc mux select depends on the exponent bit.
- done is high for exactly one cycle. busy and done are never high together.
- start while busy is ignored, and the latched inputs are unaffected.
- start in the same cycle done is high: state is IDLE at that edge only after done. A start coinciding with the done cycle is accepted, i.e. back-to-back operation with no gap.
- mm_a/mm_b hold their last values in IDLE.
- exp=0 gives result=one. exp=1 gives result=base·one-normalised. For a plain modmul that is base mod p, with the modmul defining reduction.
- No width growth: all field values are 255 bits and the controller does no arithmetic on them. i is clog2(EXP_W) bits and w is clog2(MM_LAT) bits, minimum 1 each.

Test Plan:
All scenarios use a bench model modmul: a plain (A·B) mod p delay line, p=2^255-19, latency MM_LAT.
1. EXP_W=4, MM_LAT=3, base=3, exp=5, one=1, start at t0 → done pulse at exactly t0+24, result=243, busy high for 24 cycles.
2. EXP_W=4, exp=0, base=7 → result=1. exp=1, base=7 → result=7. Both complete in 24 cycles.
3. EXP_W=255, base=2, exp=p-1 → result=1 (Fermat) at t0+1530. Also base=2, exp=p-2, then check result·2 mod p = 1.
4. Start pulsed again at t0+10 while busy with different base → ignored, result matches the first request. Start held high through done → second run accepted on the next edge, with correct result.
5. rst asserted at t0+12 mid-run → next cycle shows busy=0, done=0, result=0, mm_a=mm_b=0, and no done pulse ever appears. A new start then computes 3^5=243 correctly.
6. Constant-time check with EXP_W=8: exp=0x00 and exp=0xFF → identical done cycle and identical mm_a/mm_b issue timing.

Source files
------------

// File: rtl/modexp_ctrl.sv
// Constant-time left-to-right square-and-multiply controller driving an external
// modmul pipeline; every exponent bit costs one square plus one always-issued multiply.
module modexp_ctrl #(
  parameter int EXP_W  = 255,
  parameter int MM_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [254:0]     base,
  input  logic [EXP_W-1:0] exp,
  input  logic [254:0]     one,
  output logic             busy,
  output logic             done,
  output logic [254:0]     result,
  output logic [254:0]     mm_a,
  output logic [254:0]     mm_b,
  input  logic [254:0]     mm_d
);

  // state | meaning
  // IDLE  | waiting for start, result held
  // SQR   | acc*acc in flight on the modmul
  // MUL   | acc*base in flight, kept only when the exponent bit is set
  typedef enum logic [1:0] {IDLE, SQR, MUL} state_t;

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam int WW = (MM_LAT > 1) ? $clog2(MM_LAT) : 1;

  state_t           state_q, state_d;
  logic [254:0]     acc_q, base_q;
  logic [EXP_W-1:0] exp_q;
  logic [IW-1:0]    i_q;
  logic [WW-1:0]    w_q;
  logic             op_last;
  logic [254:0]     acc_new;

  always_comb begin
    state_d = state_q;
    op_last = (w_q == WW'(MM_LAT - 1));
    // The only exponent-dependent decision: which value the accumulator keeps.
    acc_new = exp_q[i_q] ? mm_d : acc_q;
    case (state_q)
      IDLE:    if (start) state_d = SQR;
      SQR:     if (op_last) state_d = MUL;
      MUL:     if (op_last) state_d = (i_q == '0) ? IDLE : SQR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      base_q <= '0;
      exp_q  <= '0;
      i_q    <= '0;
      w_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      mm_a   <= '0;
      mm_b   <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q <= base;
            exp_q  <= exp;
            acc_q  <= one;
            i_q    <= IW'(EXP_W - 1);
            w_q    <= '0;
            mm_a   <= one;
            mm_b   <= one;
            busy   <= 1'b1;
          end
        end
        SQR: begin
          if (op_last) begin
            acc_q <= mm_d;
            mm_a  <= mm_d;
            mm_b  <= base_q;
            w_q   <= '0;
          end else begin
            w_q <= w_q + 1'b1;
          end
        end
        MUL: begin
          if (op_last) begin
            acc_q <= acc_new;
            w_q   <= '0;
            if (i_q != '0) begin
              i_q  <= i_q - 1'b1;
              mm_a <= acc_new;
              mm_b <= acc_new;
            end else begin
              result <= acc_new;
              done   <= 1'b1;
              busy   <= 1'b0;
            end
          end else begin
            w_q <= w_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: three instances (EXP_W 4, 8, 255) each fed by a plain
// (A*B) mod p delay-line modmul; results checked against a right-to-left power model.
module tb_modexp_ctrl;

  localparam int MM_LAT = 3;
  localparam logic [254:0] P = ~255'd0 - 255'd18;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_v = 1'b0;
  logic [254:0] base_v = '0, exp_v = '0, one_v = 255'd1;
  int           sel = 0;

  logic [2:0]   start_i;
  logic         busy_i [3];
  logic         done_i [3];
  logic [254:0] result_i [3], mm_a_i [3], mm_b_i [3], mm_d_i [3];
  logic [254:0] s1 [3], s2 [3];

  logic         busy_v, done_v;
  logic [254:0] result_v, mm_a_v, mm_b_v;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  modexp_ctrl #(.EXP_W(4), .MM_LAT(MM_LAT)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_i[0]), .base(base_v), .exp(exp_v[3:0]), .one(one_v),
    .busy(busy_i[0]), .done(done_i[0]), .result(result_i[0]),
    .mm_a(mm_a_i[0]), .mm_b(mm_b_i[0]), .mm_d(mm_d_i[0]));

  modexp_ctrl #(.EXP_W(8), .MM_LAT(MM_LAT)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_i[1]), .base(base_v), .exp(exp_v[7:0]), .one(one_v),
    .busy(busy_i[1]), .done(done_i[1]), .result(result_i[1]),
    .mm_a(mm_a_i[1]), .mm_b(mm_b_i[1]), .mm_d(mm_d_i[1]));

  modexp_ctrl #(.EXP_W(255), .MM_LAT(MM_LAT)) u_dut255 (
    .clk(clk), .rst(rst), .start(start_i[2]), .base(base_v), .exp(exp_v), .one(one_v),
    .busy(busy_i[2]), .done(done_i[2]), .result(result_i[2]),
    .mm_a(mm_a_i[2]), .mm_b(mm_b_i[2]), .mm_d(mm_d_i[2]));

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
    logic [509:0] pr;
    pr = {255'd0, a} * {255'd0, b};
    return 255'(pr % {255'd0, P});
  endfunction

  function automatic logic [254:0] modpow(input logic [254:0] b, input logic [254:0] e, input int w);
    logic [254:0] r, x;
    r = 255'd1;
    x = b;
    for (int k = 0; k < w; k++) begin
      if (e[k]) r = mulmod(r, x);
      x = mulmod(x, x);
    end
    return r;
  endfunction

  // Modmul model: operands set at edge k are sampled as a product at edge k+MM_LAT.
  always @(posedge clk) begin
    for (int j = 0; j < 3; j++) begin
      s1[j] <= mulmod(mm_a_i[j], mm_b_i[j]);
      s2[j] <= s1[j];
    end
  end
  assign mm_d_i[0] = s2[0];
  assign mm_d_i[1] = s2[1];
  assign mm_d_i[2] = s2[2];

  always_comb begin
    start_i = '0;
    if (start_v) start_i[sel] = 1'b1;
    busy_v   = busy_i[sel];
    done_v   = done_i[sel];
    result_v = result_i[sel];
    mm_a_v   = mm_a_i[sel];
    mm_b_v   = mm_b_i[sel];
  end

  task automatic check(input string tag, input logic [254:0] got, input logic [254:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [254:0] rand_fe();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    if (r[254:0] >= P) return r[254:0] - P;
    return r[254:0];
  endfunction

  // One request on instance s; checks operand issue schedule, busy/done timing and result.
  task automatic run_op(input int s, input logic [254:0] b, input logic [254:0] e,
                        input bit chained, input bit hold_start, input bit disturb);
    int w, nt;
    logic [254:0] opa[$], opb[$];
    logic [254:0] acc, sq, want;
    w = (s == 0) ? 4 : (s == 1) ? 8 : 255;
    nt = 2 * w * MM_LAT;
    acc = 255'd1;
    for (int k = w - 1; k >= 0; k--) begin
      opa.push_back(acc);
      opb.push_back(acc);
      sq = mulmod(acc, acc);
      opa.push_back(sq);
      opb.push_back(b);
      acc = e[k] ? mulmod(sq, b) : sq;
    end
    want = modpow(b, e, w);
    sel = s;
    if (!chained) @(negedge clk);
    base_v = b;
    exp_v = e;
    one_v = 255'd1;
    start_v = 1'b1;
    @(posedge clk);
    for (int n = 0; n < nt; n++) begin
      @(negedge clk);
      if (n == 0 && !hold_start) start_v = 1'b0;
      if (disturb && n == 9) begin
        start_v = 1'b1;
        base_v = b + 255'd5;
        exp_v = ~e;
      end
      if (disturb && n == 10) begin
        start_v = 1'b0;
        base_v = b;
        exp_v = e;
      end
      check("busy_run", 255'(busy_v), 255'd1);
      check("done_early", 255'(done_v), 255'd0);
      check("mm_a_issue", mm_a_v, opa[n / MM_LAT]);
      check("mm_b_issue", mm_b_v, opb[n / MM_LAT]);
      @(posedge clk);
    end
    @(negedge clk);
    check("done_at_t0+2WL", 255'(done_v), 255'd1);
    check("busy_at_done", 255'(busy_v), 255'd0);
    check("result", result_v, want);
    if (!hold_start) begin
      @(posedge clk);
      @(negedge clk);
      check("done_one_cycle", 255'(done_v), 255'd0);
      check("result_held", result_v, want);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saw_done;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_busy", 255'(busy_v), 255'd0);
      check("rst_done", 255'(done_v), 255'd0);
      check("rst_result", result_v, 255'd0);
      check("rst_mm_a", mm_a_v, 255'd0);
      check("rst_mm_b", mm_b_v, 255'd0);
    end
    rst = 1'b0;

    run_op(0, 255'd3, 255'd5, 0, 0, 0);
    run_op(0, 255'd7, 255'd0, 0, 0, 0);
    run_op(0, 255'd7, 255'd1, 0, 0, 0);

    run_op(0, 255'd3, 255'd5, 0, 0, 1);
    run_op(0, 255'd3, 255'd5, 0, 1, 0);
    run_op(0, 255'd7, 255'd6, 1, 0, 0);

    run_op(1, 255'd5, 255'h00, 0, 0, 0);
    run_op(1, 255'd5, 255'hFF, 0, 0, 0);

    for (int r = 0; r < 4; r++) run_op(0, rand_fe(), 255'($urandom_range(0, 15)), 0, 0, 0);
    for (int r = 0; r < 4; r++) run_op(1, rand_fe(), 255'($urandom_range(0, 255)), 0, 0, 0);

    run_op(2, 255'd2, P - 255'd1, 0, 0, 0);
    run_op(2, 255'd2, P - 255'd2, 0, 0, 0);
    check("fermat_inv", mulmod(result_v, 255'd2), 255'd1);
    run_op(2, rand_fe(), rand_fe(), 0, 0, 0);

    // Reset in the middle of a run on the 4-bit instance.
    sel = 0;
    @(negedge clk);
    base_v = 255'd3;
    exp_v = 255'd5;
    start_v = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 11; n++) begin
      @(negedge clk);
      start_v = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", 255'(busy_v), 255'd0);
    check("mid_rst_done", 255'(done_v), 255'd0);
    check("mid_rst_result", result_v, 255'd0);
    check("mid_rst_mm_a", mm_a_v, 255'd0);
    check("mid_rst_mm_b", mm_b_v, 255'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      saw_done |= done_v;
    end
    check("no_done_after_rst", 255'(saw_done), 255'd0);
    run_op(0, 255'd3, 255'd5, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
